// File: rtl/tiny_alu_pkg.sv
// Shared opcode encoding and scheduler types for the tiny_alu family.
package tiny_alu_pkg;

  localparam int unsigned OPCODE_BITS = 3;

  localparam logic [OPCODE_BITS-1:0] NOP_OP = 3'd0;
  localparam logic [OPCODE_BITS-1:0] ADD_OP = 3'd1;
  localparam logic [OPCODE_BITS-1:0] AND_OP = 3'd2;
  localparam logic [OPCODE_BITS-1:0] XOR_OP = 3'd3;
  localparam logic [OPCODE_BITS-1:0] MUL_OP = 3'd4;

  localparam int unsigned DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } tiny_alu_sched_state_t;

endpackage

// File: rtl/tiny_alu_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module tiny_alu_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id
);

  logic        w_found;
  int unsigned w_idx;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = (32'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[ID_W'(w_idx)]) begin
        w_found = 1'b1;
        o_id    = ID_W'(w_idx);
        o_grant = NUM_REQ'(1) << ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/tiny_alu_scheduler.sv
// Shares one tiny_alu between NUM_REQ requesters: round-robin accept, issue,
// wait for done (or time out) and return the response to the originator.
module tiny_alu_scheduler
  import tiny_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ         = DEFAULT_NUM_REQ,
  parameter int unsigned INPUT_DATA_BITS = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*OPCODE_BITS-1:0] req_opcode_i,
  input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_a_i,
  input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_b_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [2*INPUT_DATA_BITS-1:0]   rsp_result_o,
  output logic                           rsp_err_o,
  output logic                           alu_start_o,
  output logic [OPCODE_BITS-1:0]         alu_opcode_o,
  output logic [INPUT_DATA_BITS-1:0]     alu_a_o,
  output logic [INPUT_DATA_BITS-1:0]     alu_b_o,
  input  logic [2*INPUT_DATA_BITS-1:0]   alu_result_i,
  input  logic                           alu_done_i
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RES_W = 2 * INPUT_DATA_BITS;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  tiny_alu_sched_state_t r_state;
  logic [ID_W-1:0]            r_ptr;
  logic [ID_W-1:0]            r_id;
  logic [OPCODE_BITS-1:0]     r_opcode;
  logic [INPUT_DATA_BITS-1:0] r_a;
  logic [INPUT_DATA_BITS-1:0] r_b;
  logic [TMR_W-1:0]           r_timer;
  logic                       r_alu_start;
  logic [NUM_REQ-1:0]         r_rsp_valid;
  logic [RES_W-1:0]           r_result;
  logic                       r_err;

  logic [NUM_REQ-1:0]         w_grant;
  logic [ID_W-1:0]            w_grant_id;
  logic [OPCODE_BITS-1:0]     w_sel_op;
  logic [INPUT_DATA_BITS-1:0] w_sel_a;
  logic [INPUT_DATA_BITS-1:0] w_sel_b;
  logic                       w_idle;
  logic [ID_W-1:0]            w_ptr_next;

  tiny_alu_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_grant_id)
  );

  // Payload mux for the winning requester.
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_grant[k]) begin
        w_sel_op = req_opcode_i[k*OPCODE_BITS +: OPCODE_BITS];
        w_sel_a  = req_a_i[k*INPUT_DATA_BITS +: INPUT_DATA_BITS];
        w_sel_b  = req_b_i[k*INPUT_DATA_BITS +: INPUT_DATA_BITS];
      end
    end
  end

  assign w_idle      = (r_state == IDLE) && !reset_i;
  assign req_ready_o = w_idle ? w_grant : '0;
  assign w_ptr_next  = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_opcode    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_timer     <= '0;
      r_alu_start <= 1'b0;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_id        <= w_grant_id;
            r_opcode    <= w_sel_op;
            r_a         <= w_sel_a;
            r_b         <= w_sel_b;
            r_alu_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_alu_start <= 1'b0;
          r_timer     <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          // Done wins over a timeout landing in the same cycle.
          if (alu_done_i) begin
            r_result    <= alu_result_i;
            r_err       <= 1'b0;
            r_rsp_valid <= NUM_REQ'(1) << r_id;
            r_state     <= RESP;
          end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            r_result    <= '0;
            r_err       <= 1'b1;
            r_rsp_valid <= NUM_REQ'(1) << r_id;
            r_state     <= RESP;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i[r_id]) begin
            r_rsp_valid <= '0;
            r_ptr       <= w_ptr_next;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_result;
  assign rsp_err_o    = r_err;
  assign alu_start_o  = r_alu_start;
  assign alu_opcode_o = r_opcode;
  assign alu_a_o      = r_a;
  assign alu_b_o      = r_b;

endmodule

// File: tb/tb_tiny_alu_scheduler.sv
// Directed bench for tiny_alu_scheduler with a behavioural single-cycle ALU.
module tb_tiny_alu_scheduler;
  import tiny_alu_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*OPCODE_BITS-1:0] req_opcode_i;
  logic [NR*DW-1:0]  req_a_i;
  logic [NR*DW-1:0]  req_b_i;
  logic [NR-1:0]     rsp_valid_o;
  logic [NR-1:0]     rsp_ready_i;
  logic [2*DW-1:0]   rsp_result_o;
  logic              rsp_err_o;
  logic              alu_start_o;
  logic [OPCODE_BITS-1:0] alu_opcode_o;
  logic [DW-1:0]     alu_a_o;
  logic [DW-1:0]     alu_b_o;
  logic [2*DW-1:0]   alu_result_i;
  logic              alu_done_i;

  logic              m_done;
  logic [2*DW-1:0]   m_res;
  logic              force_done;
  logic [2*DW-1:0]   force_res;

  int n_cmp = 0;
  int n_bad = 0;

  tiny_alu_scheduler #(
    .NUM_REQ         (NR),
    .INPUT_DATA_BITS (DW),
    .TIMEOUT_CYCLES  (4)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_opcode_i (req_opcode_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_err_o    (rsp_err_o),
    .alu_start_o  (alu_start_o),
    .alu_opcode_o (alu_opcode_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_result_i (alu_result_i),
    .alu_done_i   (alu_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Registered ALU: done one cycle after start; illegal opcodes never finish.
  always @(posedge clk_i) begin
    if (reset_i) begin
      m_done <= 1'b0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (alu_start_o) begin
        case (alu_opcode_o)
          NOP_OP: begin m_res <= '0; m_done <= 1'b1; end
          ADD_OP: begin m_res <= 16'(alu_a_o) + 16'(alu_b_o); m_done <= 1'b1; end
          AND_OP: begin m_res <= 16'(alu_a_o & alu_b_o); m_done <= 1'b1; end
          XOR_OP: begin m_res <= 16'(alu_a_o ^ alu_b_o); m_done <= 1'b1; end
          MUL_OP: begin m_res <= 16'(alu_a_o) * 16'(alu_b_o); m_done <= 1'b1; end
          default: m_done <= 1'b0;
        endcase
      end
    end
  end

  assign alu_done_i   = m_done | force_done;
  assign alu_result_i = force_done ? force_res : m_res;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_req(input int k, input logic [OPCODE_BITS-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_opcode_i[k*OPCODE_BITS +: OPCODE_BITS] = op;
    req_a_i[k*DW +: DW] = a;
    req_b_i[k*DW +: DW] = b;
  endtask

  // Waits (bounded) until a handshake will occur at the next rising edge.
  task automatic wait_accept(output int id, output int waited);
    waited = 0;
    id = -1;
    #1;
    while (((req_ready_o & req_valid_i) == '0) && waited < 40) begin
      tick();
      #1;
      waited++;
    end
    check_eq("accept_seen", 32'(|(req_ready_o & req_valid_i)), 32'd1);
    for (int k = 0; k < int'(NR); k++)
      if (req_ready_o[k]) id = k;
  endtask

  initial begin
    int id;
    int waited;
    int k;

    reset_i      = 1'b1;
    req_valid_i  = '0;
    req_opcode_i = '0;
    req_a_i      = '0;
    req_b_i      = '0;
    rsp_ready_i  = '1;
    force_done   = 1'b0;
    force_res    = '0;

    // Reset values, and no ready while reset is held.
    tick();
    req_valid_i = 4'b1111;
    tick();
    check_eq("rst_req_ready", 32'(req_ready_o), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check_eq("rst_alu_start", 32'(alu_start_o), 32'h0);
    check_eq("rst_alu_ops", {16'(alu_a_o), 8'(alu_b_o), 8'(alu_opcode_o)}, 32'h0);
    check_eq("rst_result", {15'(rsp_result_o), 16'h0, rsp_err_o}, 32'h0);
    req_valid_i = '0;
    reset_i = 1'b0;
    tick();

    // Single op: requester 1 ADD 200+100.
    set_req(1, ADD_OP, 8'd200, 8'd100);
    req_valid_i = 4'b0010;
    wait_accept(id, waited);
    check_eq("single_id", 32'(id), 32'd1);
    tick();
    req_valid_i = '0;
    check_eq("single_start", 32'(alu_start_o), 32'd1);
    check_eq("single_alu_op", {16'(alu_a_o), 8'(alu_b_o), 8'(alu_opcode_o)}, {16'd200, 8'd100, 8'd1});
    check_eq("single_no_rsp_early", 32'(rsp_valid_o), 32'h0);
    tick();
    check_eq("single_start_once", 32'(alu_start_o), 32'd0);
    tick();
    check_eq("single_rsp_valid", 32'(rsp_valid_o), 32'h2);
    check_eq("single_result", 32'(rsp_result_o), 32'd300);
    check_eq("single_err", 32'(rsp_err_o), 32'd0);
    tick();

    // Fairness: fresh pointer, all four requesters continuously MUL 255*255.
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int r = 0; r < int'(NR); r++) set_req(r, MUL_OP, 8'd255, 8'd255);
    req_valid_i = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      wait_accept(id, waited);
      check_eq("rr_order", 32'(id), 32'(n % 4));
      if (n > 0) check_eq("rr_gap", 32'(waited), 32'd0);
      tick();
      tick();
      tick();
      check_eq("rr_rsp_valid", 32'(rsp_valid_o), 32'(1 << n % 4));
      check_eq("rr_result", 32'(rsp_result_o), 32'd65025);
      tick();
    end
    req_valid_i = '0;

    // Illegal opcode on requester 2 times out after TIMEOUT_CYCLES+2.
    set_req(2, 3'd7, 8'd1, 8'd2);
    req_valid_i = 4'b0100;
    wait_accept(id, waited);
    check_eq("timeout_id", 32'(id), 32'd2);
    tick();
    req_valid_i = '0;
    k = 1;
    while (rsp_valid_o == '0 && k < 20) begin
      tick();
      k++;
    end
    check_eq("timeout_latency", 32'(k), 32'd6);
    check_eq("timeout_rsp_valid", 32'(rsp_valid_o), 32'h4);
    check_eq("timeout_err", 32'(rsp_err_o), 32'd1);
    check_eq("timeout_result", 32'(rsp_result_o), 32'd0);
    tick();

    // Backpressure: requester 3 XOR held in RESP while requester 0 waits.
    rsp_ready_i = '0;
    set_req(3, XOR_OP, 8'hF0, 8'h3C);
    set_req(0, ADD_OP, 8'd1, 8'd2);
    req_valid_i = 4'b1001;
    wait_accept(id, waited);
    check_eq("bp_id", 32'(id), 32'd3);
    tick();
    req_valid_i = 4'b0001;
    tick();
    tick();
    check_eq("bp_rsp_valid", 32'(rsp_valid_o), 32'h8);
    check_eq("bp_result", 32'(rsp_result_o), 32'hCC);
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("bp_hold_result", 32'(rsp_result_o), 32'hCC);
      check_eq("bp_hold_valid", 32'(rsp_valid_o), 32'h8);
      check_eq("bp_no_ready", 32'(req_ready_o), 32'h0);
      check_eq("bp_no_start", 32'(alu_start_o), 32'h0);
    end
    rsp_ready_i = '1;
    req_valid_i = 4'b1001;
    tick();
    #1;
    check_eq("bp_ptr_wrap", 32'(req_ready_o), 32'h1);
    req_valid_i = '0;

    // NOP on requester 1 returns 0 without error.
    set_req(1, NOP_OP, 8'd7, 8'd9);
    req_valid_i = 4'b0010;
    wait_accept(id, waited);
    check_eq("nop_id", 32'(id), 32'd1);
    tick();
    req_valid_i = '0;
    tick();
    tick();
    check_eq("nop_rsp_valid", 32'(rsp_valid_o), 32'h2);
    check_eq("nop_result", 32'(rsp_result_o), 32'd0);
    check_eq("nop_err", 32'(rsp_err_o), 32'd0);
    tick();

    // Reset during WAIT drops the op; a stale done afterwards is ignored.
    set_req(2, 3'd7, 8'd3, 8'd4);
    req_valid_i = 4'b0100;
    wait_accept(id, waited);
    check_eq("rw_id", 32'(id), 32'd2);
    tick();
    req_valid_i = '0;
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_eq("rw_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check_eq("rw_alu_ops", {16'(alu_a_o), 8'(alu_b_o), 7'(alu_opcode_o), alu_start_o}, 32'h0);
    force_done = 1'b1;
    force_res  = 16'h1234;
    set_req(1, ADD_OP, 8'd5, 8'd6);
    set_req(3, ADD_OP, 8'd1, 8'd1);
    req_valid_i = 4'b1010;
    wait_accept(id, waited);
    check_eq("rw_ptr_zero", 32'(id), 32'd1);
    check_eq("rw_stale_done", 32'(rsp_valid_o), 32'h0);
    tick();
    force_done = 1'b0;
    req_valid_i = '0;
    check_eq("rw_start", 32'(alu_start_o), 32'd1);
    check_eq("rw_no_rsp", 32'(rsp_valid_o), 32'h0);
    tick();
    tick();
    check_eq("rw_rsp_valid2", 32'(rsp_valid_o), 32'h2);
    check_eq("rw_result", 32'(rsp_result_o), 32'd11);
    tick();

    // Done arriving in the last timeout cycle wins over the timeout.
    set_req(2, 3'd7, 8'd8, 8'd9);
    req_valid_i = 4'b0100;
    wait_accept(id, waited);
    check_eq("col_id", 32'(id), 32'd2);
    tick();
    req_valid_i = '0;
    tick();
    tick();
    tick();
    tick();
    check_eq("col_pre_rsp", 32'(rsp_valid_o), 32'h0);
    force_done = 1'b1;
    force_res  = 16'hBEEF;
    tick();
    force_done = 1'b0;
    check_eq("col_rsp_valid", 32'(rsp_valid_o), 32'h4);
    check_eq("col_err", 32'(rsp_err_o), 32'd0);
    check_eq("col_result", 32'(rsp_result_o), 32'hBEEF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
